ddr_packet_reader: RTL and testbench
====================================

# ddr_packet_reader

Reads a stored test packet back out of DDR through the 256-bit external RAM request interface and serializes it into a 32-bit word stream for the SFP transmit path. It is the read-side counterpart of the DDR setup writer: it fetches a length descriptor, then the payload words, and unpacks each 256-bit word into eight 32-bit beats, lane 0 first. It sits between the DDR request/response controller and the packet transmitter, in the `clk` (clk_125_tx_rx) domain.

## Interface
- `ADDR_W`, 25, DDR word address width
- `MAX_BYTES`, 1536, largest legal packet length in bytes
- `TIMEOUT`, 1024, cycles to wait for `rd_valid` before aborting
- `clk` in 1: single clock (clk_125_tx_rx)
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle request to read one packet; ignored while `busy`
- `base_adr` in ADDR_W: descriptor word address, sampled on accepted `start`
- `rd_rq` out 1: one-cycle read request to the DDR controller
- `rd_adr` out ADDR_W: read address, valid while `rd_rq`=1
- `rd_valid` in 1: one-cycle strobe qualifying `rd_data`
- `rd_data` in 256: returned DDR word
- `tx_data` out 32: stream beat
- `tx_valid` out 1: beat valid
- `tx_ready` in 1: downstream accept
- `tx_sop`/`tx_eop` out 1: first/last beat of the packet
- `busy` out 1: high from accepted `start` until `done`
- `done` out 1: one-cycle pulse at packet end or abort
- `error` out 1: sticky until the next accepted `start`; length illegal or timeout

## Operation
- States: IDLE, REQ_HDR, WAIT_HDR, REQ_DATA, WAIT_DATA, SEND, FINISH.
- IDLE: on `start` latch `base_adr`, clear `error`, go to REQ_HDR.
- REQ_HDR: assert `rd_rq` with `rd_adr`=`base_adr` for one cycle, go to WAIT_HDR.
- WAIT_HDR: on `rd_valid` take `len`=`rd_data[31:0]` (bytes). If `len`=0 or `len`>MAX_BYTES, set `error` and go to FINISH. Otherwise compute `beats`=ceil(len/4) and `words`=ceil(beats/8), set data pointer `base_adr`+1, and go to REQ_DATA.
- REQ_DATA: one-cycle `rd_rq` at the pointer, then WAIT_DATA. On `rd_valid`, load the 256-bit word into the unpacker and go to SEND.
- SEND: present lane k=`word[32k+31:32k]`, k=0..7. A beat transfers when `tx_valid & tx_ready`. `tx_sop` is asserted on global beat 0. `tx_eop` is asserted on global beat `beats`-1. After the last lane of a word, or after the eop beat, either increment the pointer and go to REQ_DATA or, if eop was sent, go to FINISH. Unused lanes in the final word are never presented.
- FINISH: pulse `done` and return to IDLE.
- Timeout: a cycle counter in WAIT_HDR/WAIT_DATA. When it reaches TIMEOUT−1 with no `rd_valid`, set `error` and go to FINISH. If a beat was already sent, drive a final `tx_valid` with `tx_eop`=1 and `tx_data`=0 before FINISH so the packet closes.
- `rd_valid` outside the WAIT states is ignored.
- Pointer arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values: `rd_rq`=0, `rd_adr`=0, `tx_valid`=0, `tx_sop`=0, `tx_eop`=0, `tx_data`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- `start` → `rd_rq` high on the next cycle, so `rd_rq` first appears 1 cycle after `start`.
- `rd_valid` → first `tx_valid` 1 cycle later, registered.
- At most one outstanding read request; no request is issued while in SEND.
- AXI-style hold rule: `tx_data`, `tx_sop`, `tx_eop` are stable while `tx_valid`=1 and `tx_ready`=0. `tx_valid` is never dropped without a transfer.
- With `tx_ready` held high, beats stream back-to-back within a word; the word gap is 2 cycles plus the DDR latency.
- `done` is asserted the cycle after the eop transfer, or the cycle after the error decision.
- `busy` falls together with `done`.
- Reset mid-packet aborts immediately to the reset values; no `done` pulse.

## Structure
- Package `ddr_pkt_pkg` holds:
  - the state enum
  - `DDR_W`=256, `LANE_W`=32, `LANES`=8
  - the byte→beat and beat→word ceiling helpers
- Sub-module `ddr_word_unpacker` takes a 256-bit load and produces lane selection with valid/ready and a last-lane flag. The FSM, counters and timeout stay in the top.

## Test plan
- `base_adr`=0, descriptor `len`=0x40, words 1–2 hold 0x000014CC, 0x2005BF6B, … with `tx_ready`=1 → 16 beats in stored order, sop on beat 0, eop on beat 15, one `done`, `error`=0.
- `len`=13 → 4 beats, eop on beat 3, only one data read issued.
- Random `tx_ready` back-pressure at 50% → identical beat sequence, and data/sop/eop held stable on stalled cycles.
- `len`=0 and `len`=MAX_BYTES+1 → no `tx_valid`, `error`=1, `done` pulse, `busy` low afterward.
- `rd_valid` withheld on the second data word → after TIMEOUT cycles, a zero eop beat, then `error`=1 and `done`.
- `reset` asserted during SEND, then `start` again → all outputs return to reset values, and the second read completes correctly.

Source files
------------

// File: rtl/ddr_packet_reader_pkg.sv
// Shared types, widths and length helpers for the DDR packet reader.
package ddr_pkt_pkg;

  localparam int DDR_W      = 256;
  localparam int LANE_W     = 32;
  localparam int LANES      = 8;
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int CNT_W      = 16;   // beat counters; covers any legal packet length

  typedef enum logic [2:0] {
    IDLE,
    REQ_HDR,
    WAIT_HDR,
    REQ_DATA,
    WAIT_DATA,
    SEND,
    FINISH
  } state_t;

  // Number of 32-bit beats needed to carry len bytes (rounded up).
  function automatic logic [CNT_W-1:0] bytes_to_beats(input logic [31:0] len);
    logic [31:0] b;
    b = (len + 32'd3) >> 2;
    return b[CNT_W-1:0];
  endfunction

  // Number of 256-bit DDR words needed to carry a beat count (rounded up).
  function automatic logic [CNT_W-1:0] beats_to_words(input logic [CNT_W-1:0] beats);
    logic [CNT_W:0] w;
    w = ({1'b0, beats} + (CNT_W+1)'(LANES - 1)) >> LANE_IDX_W;
    return w[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ddr_packet_reader_if.sv
// Control, DDR read-request and transmit-stream signals of the packet reader.
interface ddr_packet_reader_if
  import ddr_pkt_pkg::*;
#(
  parameter int ADDR_W = 25
);
  logic              start;
  logic [ADDR_W-1:0] base_adr;
  logic              rd_rq;
  logic [ADDR_W-1:0] rd_adr;
  logic              rd_valid;
  logic [DDR_W-1:0]  rd_data;
  logic [LANE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sop;
  logic              tx_eop;
  logic              busy;
  logic              done;
  logic              error;

  // Environment side: issues start, answers reads, accepts the stream.
  modport master (
    output start, base_adr, rd_valid, rd_data, tx_ready,
    input  rd_rq, rd_adr, tx_data, tx_valid, tx_sop, tx_eop, busy, done, error
  );

  // Reader side.
  modport slave (
    input  start, base_adr, rd_valid, rd_data, tx_ready,
    output rd_rq, rd_adr, tx_data, tx_valid, tx_sop, tx_eop, busy, done, error
  );
endinterface

// File: rtl/ddr_packet_reader_unpacker.sv
// Holds one 256-bit DDR word and walks its eight 32-bit lanes, lane 0 first.
// stop_i ends the word early when the current lane is the packet's last beat.
module ddr_word_unpacker
  import ddr_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DDR_W-1:0]  word_i,
  input  logic              ready_i,
  input  logic              stop_i,
  output logic              valid_o,
  output logic [LANE_W-1:0] lane_data_o,
  output logic              last_lane_o
);

  logic [DDR_W-1:0]      word_q;
  logic [LANE_IDX_W-1:0] lane_q;
  logic                  valid_q;
  logic [LANE_W-1:0]     lanes [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes[gi] = word_q[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign valid_o     = valid_q;
  assign lane_data_o = lanes[lane_q];
  assign last_lane_o = (lane_q == LANE_IDX_W'(LANES - 1));

  // Capture a new word, or step to the next lane on each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      lane_q  <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      if (last_lane_o || stop_i) begin
        valid_q <= 1'b0;
      end else begin
        lane_q <= lane_q + LANE_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_packet_reader.sv
// Reads a length descriptor and payload from DDR and streams it as 32-bit beats.
// One read is outstanding at a time; a read timeout closes an already started
// packet with a zero-data eop beat so the transmitter never sees a dangling frame.
module ddr_packet_reader
  import ddr_pkt_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int MAX_BYTES = 1536,
  parameter int TIMEOUT   = 1024
)(
  input  logic               clk,
  input  logic               reset,
  ddr_packet_reader_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              error_q, error_d;
  logic              abort_q, abort_d;   // sending the closing zero beat after a timeout

  logic              unp_load;
  logic              unp_ready;
  logic              unp_valid;
  logic              unp_last;
  logic [LANE_W-1:0] unp_data;

  logic [31:0]       hdr_len;
  logic              tmo_expired;
  logic              is_eop;
  logic              tx_valid;
  logic              tx_fire;

  assign hdr_len     = bus.rd_data[31:0];
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign is_eop      = (beat_cnt_q == beats_q - CNT_W'(1));
  assign tx_valid    = (state_q == SEND) && (abort_q || unp_valid);
  assign tx_fire     = tx_valid && bus.tx_ready;
  assign unp_ready   = bus.tx_ready && (state_q == SEND) && !abort_q;

  ddr_word_unpacker u_unpacker (
    .clk         (clk),
    .rst         (reset),
    .load_i      (unp_load),
    .word_i      (bus.rd_data),
    .ready_i     (unp_ready),
    .stop_i      (is_eop),
    .valid_o     (unp_valid),
    .lane_data_o (unp_data),
    .last_lane_o (unp_last)
  );

  // Outputs decode from registered state, so they hold steady while stalled.
  assign bus.rd_rq    = (state_q == REQ_HDR) || (state_q == REQ_DATA);
  assign bus.rd_adr   = ptr_q;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = (tx_valid && !abort_q) ? unp_data : '0;
  assign bus.tx_sop   = tx_valid && !abort_q && (beat_cnt_q == '0);
  assign bus.tx_eop   = tx_valid && (abort_q || is_eop);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == FINISH);
  assign bus.error    = error_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic: descriptor fetch, word fetch, beat sequencing, timeout.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    tmo_d      = '0;
    error_d    = error_q;
    abort_d    = abort_q;
    unp_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ptr_d      = bus.base_adr;
          error_d    = 1'b0;
          abort_d    = 1'b0;
          beat_cnt_d = '0;
          state_d    = REQ_HDR;
        end
      end

      REQ_HDR: state_d = WAIT_HDR;

      WAIT_HDR: begin
        if (bus.rd_valid) begin
          if (hdr_len == 32'd0 || hdr_len > 32'(MAX_BYTES)) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            beats_d = bytes_to_beats(hdr_len);
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = REQ_DATA;
          end
        end else if (tmo_expired) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      REQ_DATA: state_d = WAIT_DATA;

      WAIT_DATA: begin
        if (bus.rd_valid) begin
          unp_load = 1'b1;
          state_d  = SEND;
        end else if (tmo_expired) begin
          error_d = 1'b1;
          if (beat_cnt_q != '0) begin
            abort_d = 1'b1;
            state_d = SEND;
          end else begin
            state_d = FINISH;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      SEND: begin
        if (tx_fire) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (abort_q || is_eop) begin
            state_d = FINISH;
          end else if (unp_last) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = REQ_DATA;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_packet_reader.sv
// Randomized bench: a DDR responder with random latency, random back-pressure,
// and a reference model that derives the beat list directly from memory contents.
module tb_ddr_packet_reader;

  localparam int ADDR_W    = 25;
  localparam int MAX_BYTES = 1536;
  localparam int TIMEOUT   = 1024;

  logic clk;
  logic reset;

  ddr_packet_reader_if #(.ADDR_W(ADDR_W)) bus ();

  ddr_packet_reader #(
    .ADDR_W    (ADDR_W),
    .MAX_BYTES (MAX_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] mem [64];          // DDR image, indexed by low address bits
  logic [33:0]  got_q [$];         // {sop, eop, data} of every transferred beat
  logic [33:0]  exp_q [$];
  int           done_cnt;
  int           rd_count;
  bit           rand_ready;
  bit           withhold_en;
  logic [ADDR_W-1:0] withhold_adr;
  bit           exp_error;
  int           exp_reads;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DDR responder: answers each request after 0..3 extra cycles unless withheld.
  initial begin : ddr_responder
    bit pend;
    int lat;
    logic [ADDR_W-1:0] a;
    pend = 0; lat = 0; a = '0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (lat == 0) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = mem[a[5:0]];
            pend = 0;
          end else begin
            lat--;
          end
        end
        if (bus.rd_rq) begin
          a = bus.rd_adr;
          rd_count++;
          if (!(withhold_en && a == withhold_adr)) begin
            pend = 1;
            lat  = $urandom_range(0, 3);
          end
        end
      end
    end
  end

  // Stream monitor: drives tx_ready, collects transfers, checks the hold rule.
  initial begin : stream_monitor
    bit stalled;
    logic [33:0] held;
    logic [33:0] cur;
    stalled = 0; held = '0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0;
      end else begin
        cur = {bus.tx_sop, bus.tx_eop, bus.tx_data};
        if (stalled) begin
          check_eq("valid_held", 64'(bus.tx_valid), 64'd1);
          check_eq("beat_held", 64'(cur), 64'(held));
        end
        if (bus.done) done_cnt++;
        bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.tx_valid && bus.tx_ready) got_q.push_back(cur);
        stalled = bus.tx_valid && !bus.tx_ready;
        held    = cur;
      end
    end
  end

  // Fill memory, then derive the expected beats, error flag and read count.
  // hold: -1 none, 0 withhold the descriptor, k>0 withhold data word k-1.
  task automatic prepare_pkt(input logic [ADDR_W-1:0] base, input logic [31:0] len,
                             input int hold, input bit rnd, input bit fixed);
    logic [255:0] w;
    logic [ADDR_W-1:0] wa;
    int nb, nw, deliver;
    w = '0;
    for (int k = 1; k < 8; k++) w[k*32 +: 32] = $urandom;
    w[31:0] = len;
    mem[base[5:0]] = w;
    for (int j = 0; j < 50; j++) begin
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
      if (fixed && j == 0) begin
        w[31:0]  = 32'h000014CC;
        w[63:32] = 32'h2005BF6B;
      end
      wa = base + ADDR_W'(1 + j);
      mem[wa[5:0]] = w;
    end

    exp_q.delete();
    if (hold == 0 || len == 0 || len > MAX_BYTES) begin
      exp_error = 1;
      exp_reads = 1;
    end else begin
      nb = (int'(len) + 3) / 4;
      nw = (nb + 7) / 8;
      if (hold > 0 && hold <= nw) begin
        deliver   = (hold - 1) * 8;
        exp_error = 1;
        exp_reads = 1 + hold;
      end else begin
        deliver   = nb;
        exp_error = 0;
        exp_reads = 1 + nw;
      end
      for (int i = 0; i < deliver; i++) begin
        wa = base + ADDR_W'(1 + i / 8);
        w  = mem[wa[5:0]];
        exp_q.push_back({(i == 0), (i == nb - 1), w[(i % 8)*32 +: 32]});
      end
      if (deliver < nb && deliver > 0) exp_q.push_back({1'b0, 1'b1, 32'd0});
    end

    withhold_en  = (hold >= 0);
    withhold_adr = base + ADDR_W'(hold < 0 ? 0 : hold);
    rand_ready   = rnd;
    got_q.delete();
    done_cnt = 0;
    rd_count = 0;
  endtask

  task automatic start_pkt(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.base_adr = base;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("rq_next_cycle", 64'(bus.rd_rq), 64'd1);
    check_eq("rq_hdr_adr", 64'(bus.rd_adr), 64'(base));
  endtask

  task automatic finish_pkt(input string name);
    int n;
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check_eq({name, "_busy_low"}, 64'(bus.busy), 64'd0);
    check_eq({name, "_error"}, 64'(bus.error), 64'(exp_error));
    check_eq({name, "_reads"}, 64'(rd_count), 64'(exp_reads));
    check_eq({name, "_beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({name, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    $display("pkt %s: beats=%0d reads=%0d error=%0d", name, got_q.size(), rd_count, bus.error);
  endtask

  task automatic run_pkt(input string name, input logic [ADDR_W-1:0] base, input logic [31:0] len,
                         input int hold, input bit rnd, input bit fixed);
    prepare_pkt(base, len, hold, rnd, fixed);
    start_pkt(base);
    finish_pkt(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_rd_rq"}, 64'(bus.rd_rq), 64'd0);
    check_eq({name, "_rd_adr"}, 64'(bus.rd_adr), 64'd0);
    check_eq({name, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
    check_eq({name, "_tx_sop"}, 64'(bus.tx_sop), 64'd0);
    check_eq({name, "_tx_eop"}, 64'(bus.tx_eop), 64'd0);
    check_eq({name, "_tx_data"}, 64'(bus.tx_data), 64'd0);
    check_eq({name, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({name, "_done"}, 64'(bus.done), 64'd0);
    check_eq({name, "_error"}, 64'(bus.error), 64'd0);
  endtask

  initial begin : main
    logic [ADDR_W-1:0] rb;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.base_adr = '0;
    rand_ready   = 0;
    withhold_en  = 0;
    withhold_adr = '0;
    done_cnt     = 0;
    rd_count     = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run_pkt("len64",      25'd0,  32'h40, -1, 0, 1);
    run_pkt("len13",      25'd10, 32'd13, -1, 0, 0);
    run_pkt("len64_bp",   25'd20, 32'h40, -1, 1, 0);
    run_pkt("len0",       25'd5,  32'd0,  -1, 1, 0);
    run_pkt("len_over",   25'd5,  32'(MAX_BYTES + 1), -1, 1, 0);
    run_pkt("tmo_word1",  25'd3,  32'h40,  2, 0, 0);
    run_pkt("tmo_hdr",    25'd7,  32'h40,  0, 0, 0);
    run_pkt("wrap",       25'h1FFFFFF, 32'd40, -1, 1, 0);
    run_pkt("len_max_bp", 25'd0,  32'(MAX_BYTES), -1, 1, 0);

    // Reset while beats are streaming, then a clean packet.
    prepare_pkt(25'd30, 32'd200, -1, 0, 0);
    start_pkt(25'd30);
    for (int c = 0; c < 2000 && got_q.size() < 3; c++) @(negedge clk);
    check_eq("mid_send_started", 64'(got_q.size() >= 3), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    check_eq("mid_reset_no_done", 64'(done_cnt), 64'd0);
    reset = 1'b0;
    run_pkt("after_reset", 25'd30, 32'd200, -1, 1, 0);

    for (int r = 0; r < 6; r++) begin
      rb = ADDR_W'($urandom);
      run_pkt("random", rb, 32'($urandom_range(1, 400)), -1, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
